// File: rtl/spi_3_pkg.sv
// Shared definitions for the spi_mode_master slice: default sizes, FSM state
// encoding and the packed command record.
package spi_3_pkg;

    localparam int DWIDTH       = 32;
    localparam int NSLAVES      = 4;
    localparam int S_ADDR_WIDTH = $clog2(NSLAVES);
    localparam int DIV_WIDTH    = 8;
    localparam int LWIDTH       = $clog2(DWIDTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_GAP,
        ST_DONE
    } spi_state_t;

    typedef struct packed {
        logic [S_ADDR_WIDTH-1:0] slave;
        logic [LWIDTH-1:0]       len;
        logic                    cpol;
        logic                    cpha;
        logic [DIV_WIDTH-1:0]    div;
        logic [DWIDTH-1:0]       data;
    } spi_cmd_t;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period timer: down-counter reloaded with div at terminal count,
// plus a phase bit that splits half-period ends into leading/trailing strobes.
module spi_clk_div #(
    parameter int DIV_WIDTH = spi_3_pkg::DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 half_end,
    output logic                 lead_edge,
    output logic                 trail_edge
);

    logic [DIV_WIDTH-1:0] cnt;
    logic                 phase;

    assign half_end   = en & (cnt == '0);
    assign lead_edge  = half_end & ~phase;
    assign trail_edge = half_end & phase;

    // load restarts the half-period and realigns the phase to a leading edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (load) begin
            cnt   <= div;
            phase <= 1'b0;
        end else if (half_end) begin
            cnt   <= div;
            phase <= ~phase;
        end else if (en) begin
            cnt   <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/spi_mode_master.sv
// SPI master with per-command mode, length, divider and chip-select selection.
// All SPI pins and handshake outputs are registered.
//
// state | meaning
// IDLE  | cmd_ready high, sclk parked at last cpol
// SETUP | cs_n asserted, first bit on mosi for cpha=0, one half-period
// XFER  | 2*(len+1) half-periods, sclk toggles at each half-period end
// HOLD  | cs_n still low for one half-period after the last edge
// GAP   | cs_n high for one half-period before reporting
// DONE  | rsp_valid pulse, back to IDLE
module spi_mode_master #(
    parameter int DWIDTH       = spi_3_pkg::DWIDTH,
    parameter int NSLAVES      = spi_3_pkg::NSLAVES,
    parameter int S_ADDR_WIDTH = $clog2(NSLAVES),
    parameter int DIV_WIDTH    = spi_3_pkg::DIV_WIDTH,
    parameter int LWIDTH       = $clog2(DWIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [S_ADDR_WIDTH-1:0] cmd_slave,
    input  logic [LWIDTH-1:0]       cmd_len,
    input  logic                    cmd_cpol,
    input  logic                    cmd_cpha,
    input  logic [DIV_WIDTH-1:0]    cmd_div,
    input  logic [DWIDTH-1:0]       cmd_data,
    output logic                    rsp_valid,
    output logic [DWIDTH-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic                    sclk,
    output logic                    mosi,
    input  logic                    miso,
    output logic [NSLAVES-1:0]      cs_n
);
    import spi_3_pkg::*;

    spi_state_t           state;
    logic [LWIDTH-1:0]    bit_cnt;
    logic                 cpha_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DWIDTH-1:0]    data_q;
    logic [DWIDTH-1:0]    rx_q;
    logic [DWIDTH-1:0]    rx_next;
    logic                 err_q;
    logic                 accept;
    logic                 div_load;
    logic [DIV_WIDTH-1:0] div_val;
    logic                 half_end;
    logic                 lead_edge;
    logic                 trail_edge;
    logic [NSLAVES-1:0]   cs_sel;

    assign accept   = cmd_valid & cmd_ready;
    assign div_load = accept | ((state == ST_SETUP) & half_end);
    assign div_val  = accept ? cmd_div : div_q;
    assign rx_next  = {rx_q[DWIDTH-2:0], miso};

    // out-of-range slave index leaves every select deasserted
    always_comb begin
        cs_sel = '1;
        for (int i = 0; i < NSLAVES; i++) begin
            if (cmd_slave == S_ADDR_WIDTH'(i)) cs_sel[i] = 1'b0;
        end
    end

    spi_clk_div #(.DIV_WIDTH(DIV_WIDTH)) u_clk_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state != ST_IDLE),
        .load      (div_load),
        .div       (div_val),
        .half_end  (half_end),
        .lead_edge (lead_edge),
        .trail_edge(trail_edge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            cs_n      <= '1;
            bit_cnt   <= '0;
            cpha_q    <= 1'b0;
            div_q     <= '0;
            data_q    <= '0;
            rx_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        cpha_q    <= cmd_cpha;
                        div_q     <= cmd_div;
                        data_q    <= cmd_data;
                        bit_cnt   <= cmd_len;
                        rx_q      <= '0;
                        err_q     <= (int'(cmd_slave) >= NSLAVES);
                        cs_n      <= cs_sel;
                        sclk      <= cmd_cpol;
                        if (!cmd_cpha) mosi <= cmd_data[cmd_len];
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (half_end) state <= ST_XFER;
                end
                ST_XFER: begin
                    if (half_end) sclk <= ~sclk;
                    if (lead_edge) begin
                        if (cpha_q) mosi <= data_q[bit_cnt];
                        else        rx_q <= rx_next;
                    end
                    if (trail_edge) begin
                        if (cpha_q) rx_q <= rx_next;
                        if (bit_cnt == '0) begin
                            state <= ST_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                            if (!cpha_q) mosi <= data_q[bit_cnt - 1'b1];
                        end
                    end
                end
                ST_HOLD: begin
                    if (half_end) begin
                        cs_n  <= '1;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (half_end) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= rx_q;
                        rsp_err   <= err_q;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
